// File: rtl/disparity_stream_pkg.sv
// Word layout shared by the disparity packer and its consumers.
// One pixel per 32-bit word: disparity, confidence, gray and three position flags.
package disparity_stream_pkg;

    localparam int unsigned WORD_W             = 32;
    localparam int unsigned PIX_W              = 8;

    localparam int unsigned FLAG_FIRST_IN_LINE = 0;
    localparam int unsigned FLAG_LAST_IN_LINE  = 1;
    localparam int unsigned FLAG_LAST_IN_FRAME = 2;

    localparam int unsigned OFS_GRAY           = 8;
    localparam int unsigned OFS_CONFIDENCE     = 16;
    localparam int unsigned OFS_DISPARITY      = 24;
    localparam int unsigned RSVD_W             = OFS_GRAY - 3;

    typedef struct packed {
        logic [PIX_W-1:0]  disparity;
        logic [PIX_W-1:0]  confidence;
        logic [PIX_W-1:0]  gray;
        logic [RSVD_W-1:0] rsvd;
        logic              last_in_frame;
        logic              last_in_line;
        logic              first_in_line;
    } px_word_t;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [PIX_W-1:0] disp,
        input logic [PIX_W-1:0] conf,
        input logic [PIX_W-1:0] gray,
        input logic             first_in_line,
        input logic             last_in_line,
        input logic             last_in_frame
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[OFS_DISPARITY  +: PIX_W]   = disp;
        w[OFS_CONFIDENCE +: PIX_W]   = conf;
        w[OFS_GRAY       +: PIX_W]   = gray;
        w[FLAG_FIRST_IN_LINE]        = first_in_line;
        w[FLAG_LAST_IN_LINE]         = last_in_line;
        w[FLAG_LAST_IN_FRAME]        = last_in_frame;
        return w;
    endfunction

endpackage

// File: rtl/disparity_stream_packer_sync_fifo.sv
// Show-ahead FIFO with a registered output word; the output register mirrors the
// head entry, so it is counted in level and freed only on a consumer pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_ready_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   rd_valid_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             pop, push;

    // Head refetch uses the pre-edge write pointer: a word written this cycle shows next cycle.
    always_comb begin
        pop      = valid_q && rd_ready_i;
        push     = wr_en_i && (!full_q || pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + PW'(push) - PW'(pop);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        valid_d  = (rd_ptr_d != wr_ptr_q);
        data_d   = valid_d ? mem_q[rd_ptr_d[AW-1:0]] : data_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;

endmodule

// File: rtl/disparity_stream_packer.sv
// Tags the filtered disparity stream with regenerated line/frame flags and buffers
// the packed words toward the frame writer; drops on overflow since the source cannot stall.
module disparity_stream_packer
    import disparity_stream_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_sync,
    input  logic [PIX_W-1:0]            disparity_in,
    input  logic [PIX_W-1:0]            confidence_in,
    input  logic [PIX_W-1:0]            gray_in,
    input  logic                        in_valid,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int unsigned X_W = $clog2(FRAME_WIDTH);
    localparam int unsigned Y_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    logic [X_W-1:0] x_q, x_d, x_cur;
    logic [Y_W-1:0] y_q, y_d, y_cur;
    logic           last_x, last_y;
    px_word_t       stage_q, stage_d;
    logic           stage_vld_q, stage_vld_d;
    logic           overflow_q, overflow_d;
    logic           fifo_full, fifo_empty, fifo_rd, drop;

    // Tagging stage: frame_sync makes the coincident pixel (0,0); counters run even on drops.
    always_comb begin
        x_cur       = frame_sync ? '0 : x_q;
        y_cur       = frame_sync ? '0 : y_q;
        last_x      = (x_cur == X_W'(FRAME_WIDTH - 1));
        last_y      = (y_cur == Y_W'(FRAME_HEIGHT - 1));
        x_d         = x_q;
        y_d         = y_q;
        stage_d     = stage_q;
        stage_vld_d = in_valid;
        if (in_valid) begin
            stage_d = px_word_t'(pack_word(disparity_in, confidence_in, gray_in,
                                           x_cur == '0, last_x, last_x && last_y));
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_cur + Y_W'(1);
            end else begin
                x_d = x_cur + X_W'(1);
                y_d = y_cur;
            end
        end else if (frame_sync) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_comb begin
        fifo_rd    = out_valid && out_ready && !fifo_empty;
        drop       = stage_vld_q && fifo_full && !fifo_rd;
        overflow_d = frame_sync ? 1'b0 : (overflow_q || drop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q         <= '0;
            y_q         <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (stage_vld_q),
        .wr_data_i  (stage_q),
        .rd_ready_i (out_ready),
        .rd_data_o  (out_data),
        .rd_valid_o (out_valid),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign overflow = overflow_q;

endmodule

// File: tb/tb_disparity_stream_packer.sv
// Directed bench for disparity_stream_packer on a 4x2 frame with a 4-entry FIFO.
module tb_disparity_stream_packer;

    localparam int unsigned FW    = 4;
    localparam int unsigned FH    = 2;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_sync;
    logic [7:0]  disparity_in, confidence_in, gray_in;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_level;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    disparity_stream_packer #(
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_sync    (frame_sync),
        .disparity_in  (disparity_in),
        .confidence_in (confidence_in),
        .gray_in       (gray_in),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [7:0] d, input logic [7:0] c,
                                       input logic [7:0] g, input logic [2:0] f);
        return {d, c, g, 5'b00000, f};
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        frame_sync = 1'b0;
        in_valid = 1'b0;
        disparity_in = 8'h00;
        confidence_in = 8'h00;
        gray_in = 8'h00;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_sync = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        disparity_in = 8'h00;
        confidence_in = 8'h00;
        gray_in = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        out_ready = 1'b1;
        disparity_in = 8'h2A; confidence_in = 8'h80; gray_in = 8'h11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_n got %0d exp 0", fifo_level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n got %b exp 0", out_valid); end
        tick();
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_n1 got %0d exp 1", fifo_level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n1 got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_n2 got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'h2A801101) begin errors++; $display("FAIL single_data got %h exp 2a801101", out_data); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_n2 got %0d exp 1", fifo_level); end
        tick();
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_n3 got %0d exp 0", fifo_level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n3 got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  flg [8];
        logic [31:0] exp;
        int          k;
        flg = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b110};
        apply_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 11; t++) begin
            if (t < 8) begin
                in_valid = 1'b1;
                disparity_in = 8'(t);
                confidence_in = 8'(8'h40 + t);
                gray_in = 8'(8'hC0 + t);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (t >= 2 && t < 10) begin
                k = t - 2;
                exp = mk(8'(k), 8'(8'h40 + k), 8'(8'hC0 + k), flg[k]);
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, out_valid); end
                checks++; if (out_data !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, out_data, exp); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid t=%0d got %b exp 0", t, out_valid); end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] drain [3];
        apply_reset();
        out_ready = 1'b0;
        confidence_in = 8'hA5;
        gray_in = 8'h5A;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            disparity_in = 8'(8'h10 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_hold got %b exp 1", out_valid); end
        checks++; if (out_data !== mk(8'h10, 8'hA5, 8'h5A, 3'b001)) begin errors++; $display("FAIL ovf_head got %h exp 10a55a01", out_data); end

        // seventh pixel lands while full, written in the same cycle as a pop
        in_valid = 1'b1;
        disparity_in = 8'h16;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL rw_full_level got %0d exp 4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rw_full_overflow got %b exp 1", overflow); end
        checks++; if (out_data !== mk(8'h11, 8'hA5, 8'h5A, 3'b000)) begin errors++; $display("FAIL rw_full_head got %h exp 11a55a00", out_data); end
        drain = '{mk(8'h12, 8'hA5, 8'h5A, 3'b000), mk(8'h13, 8'hA5, 8'h5A, 3'b010), mk(8'h16, 8'hA5, 8'h5A, 3'b000)};
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_data !== drain[i]) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_data, drain[i]); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid got %b exp 0", out_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL drain_end_level got %0d exp 0", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_frame_sync();
        logic [31:0] exp_q [$];
        logic [31:0] exp;
        logic [2:0]  flg [8];
        logic [2:0]  f;
        flg = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b110};
        apply_reset();
        out_ready = 1'b0;
        confidence_in = 8'h33;
        gray_in = 8'hCC;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            disparity_in = 8'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fs_pre_overflow got %b exp 1", overflow); end
        out_ready = 1'b1;
        repeat (6) tick();
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL fs_drained_level got %0d exp 0", fifo_level); end

        // counters now sit at (1,1); two pixels, then resync on pixel 0x80
        for (int t = 0; t < 16; t++) begin
            if (t < 10) begin
                in_valid = 1'b1;
                frame_sync = (t == 2);
                if (t < 2) begin
                    disparity_in = 8'(8'hE0 + t);
                    f = 3'b000;
                end else begin
                    disparity_in = 8'(8'h80 + t - 2);
                    f = flg[t-2];
                end
                exp_q.push_back(mk(disparity_in, 8'h33, 8'hCC, f));
            end else begin
                in_valid = 1'b0;
                frame_sync = 1'b0;
            end
            tick();
            if (t == 1) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fs_sticky got %b exp 1", overflow); end
            end
            if (t == 2) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fs_clear got %b exp 0", overflow); end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL fs_extra_word got %h exp none", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin errors++; $display("FAIL fs_word got %h exp %h", out_data, exp); end
                end
            end
        end
        frame_sync = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fs_missing_words got %0d left exp 0", exp_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fs_end_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b0;
        confidence_in = 8'h44;
        gray_in = 8'h55;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            disparity_in = 8'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got %0d exp 3", fifo_level); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_pre got %b exp 1", out_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", out_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_async_level got %0d exp 0", fifo_level); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_async_data got %h exp 00000000", out_data); end
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        disparity_in = 8'h33;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_post_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== mk(8'h33, 8'h44, 8'h55, 3'b001)) begin errors++; $display("FAIL mid_post_data got %h exp 33445501", out_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_frame_sync();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disparity_stream_packer.md
Name: disparity_stream_packer

Overview:
- Sits directly downstream of the 3x1 bilateral disparity filter; consumes its disparity/confidence/gray/valid stream, which carries no position markers.
- Regenerates line/frame position flags by counting pixels, packs each pixel into one 32-bit word, and buffers words in a FIFO behind a ready/valid interface toward the frame writer.
- The filter has no backpressure, so overflow drops pixels and raises a sticky flag.

Parameters:
- frame_width, 640, pixels per line (>=2)
- frame_height, 480, lines per frame (>=1)
- fifo_depth, 16, FIFO entries, power of two >=4

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- frame_sync  input  1  synchronous resync: next accepted pixel is pixel (0,0)
- disparity_in  input  8  filtered disparity
- confidence_in  input  8  filtered confidence
- gray_in  input  8  centre gray value
- in_valid  input  1  input pixel qualifier, single-cycle strobes, no backpressure
- out_data  output  32  packed word
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- fifo_level  output  $clog2(fifo_depth)+1  current FIFO occupancy
- overflow  output  1  sticky: at least one pixel dropped since reset or frame_sync

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, fifo_level=0, overflow=0, x_cnt=0, y_cnt=0, FIFO empty, stage register empty.
- Word format:
  - [31:24] disparity, [23:16] confidence, [15:8] gray, [7:3] zero.
  - [2] last_in_frame (x=frame_width-1 && y=frame_height-1).
  - [1] last_in_line (x=frame_width-1).
  - [0] first_in_line (x=0).
- Stage 1 (tagging): on in_valid, register the packed word using the current x_cnt/y_cnt.
  - Advance x_cnt; at frame_width-1, wrap x to 0 and advance y_cnt.
  - At the last pixel of the frame, wrap both counters to 0.
- Stage 2 (FIFO write): the registered word is written the next cycle.
  - If the FIFO is full and no read happens that cycle, the word is dropped and overflow is set.
  - Full with a simultaneous read: the write succeeds and nothing is dropped.
  - Counters always advance on in_valid, even when the word is dropped, so geometry stays aligned to the source.
- Latency: pixel sampled at edge N with the FIFO empty gives out_valid=1 after edge N+2 (show-ahead, registered output). Sustains one pixel per cycle with out_ready held high.
- Output handshake:
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - out_valid never drops without a pop.
- FIFO read and write in the same cycle: fifo_level is unchanged.
- Read on empty: ignored, no underflow.
- fifo_level is registered. It counts FIFO entries only; the stage-1 register is excluded.
- frame_sync:
  - Clears x_cnt, y_cnt and overflow in the same cycle.
  - Words already in the FIFO or stage register are untouched.
  - frame_sync together with in_valid: that pixel is tagged (0,0), first_in_line=1.
- overflow is cleared only by reset or frame_sync.
- Pointer wrap: read/write pointers carry one extra bit; full = MSBs differ and remaining bits equal.
- Reset asserted mid-frame: all state clears immediately; partial-frame words are lost.

Decomposition:
- Package disparity_stream_pkg holds:
  - word width constant (32)
  - flag bit positions (FLAG_FIRST_IN_LINE=0, FLAG_LAST_IN_LINE=1, FLAG_LAST_IN_FRAME=2)
  - field offsets
  - packed-word typedef
- Sub-module sync_fifo:
  - parameterised width/depth, show-ahead, registered output, async active-low reset
  - exposes full, empty, level

Test Plan:
- Bench params frame_width=4, frame_height=2, fifo_depth=4, out_ready=1. Drive 8 back-to-back pixels with disparity=0..7 → 8 words; flags per word 001,000,000,010,001,000,000,110; first out_valid 2 cycles after the first in_valid.
- After reset, drive one pixel (disp=0x2A, conf=0x80, gray=0x11) → out_data=0x2A801101 two cycles later; fifo_level goes 0→1→0.
- Hold out_ready=0 and drive 6 pixels → 4 words stored, 2 dropped; overflow=1; fifo_level=4; counters still advance, so the 7th pixel is tagged x=2 of line 1.
- With the FIFO full, assert out_ready and in_valid in the same cycle → no drop, overflow stays at its prior value, fifo_level stays 4.
- Feed 2 pixels, then frame_sync together with in_valid → that pixel has flags 001, overflow cleared; next frame's last pixel carries flag 110.
- Pull reset low mid-frame with 3 words buffered → out_valid=0 and fifo_level=0 asynchronously; first pixel after release is tagged (0,0).
